writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of enabled cycles spent waiting for load data before a fault is raised.
REQ-002 SHALL have port clk  input  1  the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port clk_enable  input  1  global stall; state advances only when it is 1.
REQ-005 SHALL have port wb_valid  input  1  an instruction is present from the pre-writeback register.
REQ-006 SHALL have port wb_ready  output  1  the stage can accept an instruction.
REQ-007 SHALL have port pre_wb  input  32  the pre-writeback value; this is the byte address when load_en=1.
REQ-008 SHALL have port rd  input  5  destination register index.
REQ-009 SHALL have port load_en  input  1  the instruction is a load.
REQ-010 SHALL have port load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 SHALL have port mem_req  output  1  data-memory read request.
REQ-012 SHALL have port mem_addr  output  30  word address of the read.
REQ-013 SHALL have port mem_rdata  input  32  read data word.
REQ-014 SHALL have port mem_rvalid  input  1  mem_rdata is valid this cycle.
REQ-015 SHALL have port rf_we  output  1  register-file write enable.
REQ-016 SHALL have port rf_waddr  output  5  register-file write index.
REQ-017 SHALL have port rf_wdata  output  32  register-file write data.
REQ-018 SHALL have port load_fault  output  1  one-cycle pulse reporting a misaligned, illegal or timed-out load.

Function
REQ-019 SHALL implement FSM states IDLE and LOAD_WAIT, with wb_ready = 1 only in IDLE.
REQ-020 SHALL accept an instruction when wb_valid & wb_ready & clk_enable, latching pre_wb, rd, load_en and load_funct3.
REQ-021 SHALL, for an accepted non-load, assert rf_we on the next enabled cycle with rf_waddr=rd and rf_wdata=pre_wb, then remain in IDLE (1-cycle latency).
REQ-022 SHALL, for an accepted legal, aligned load, enter LOAD_WAIT and assert mem_req with mem_addr=pre_wb[31:2] from the next cycle until mem_rvalid is sampled.
REQ-023 SHALL, in LOAD_WAIT on an enabled cycle with mem_rvalid=1, drop mem_req, return to IDLE, and assert rf_we the following cycle with extracted data.
REQ-024 SHALL extract load data using byte offset pre_wb[1:0]: LB/LBU select byte mem_rdata[8*off+7:8*off]; LH/LHU select halfword off[1]; LW selects the whole word.
REQ-025 SHALL sign-extend LB and LH to 32 bits, and zero-extend LBU and LHU to 32 bits.
REQ-026 SHALL treat the following as faults, which pulse load_fault one cycle after accept, issue no mem_req, perform no write and stay in IDLE: LH/LHU with pre_wb[0]=1, LW with pre_wb[1:0]!=0, and load_funct3 of 011, 110 or 111.
REQ-027 SHALL count enabled cycles in LOAD_WAIT; when the count reaches TIMEOUT_CYCLES with no mem_rvalid, it SHALL pulse load_fault, drop mem_req and return to IDLE without writing.
REQ-028 SHALL ignore mem_rvalid while in IDLE, including a late response after a timeout.
REQ-029 SHALL still complete the handshake when rd=0, but keep rf_we at 0 (x0 is never written).
REQ-030 SHALL make rf_we and load_fault one-enabled-cycle pulses that clear on the next enabled cycle.
REQ-031 SHALL, while clk_enable=0, hold all state including the timeout count, ignore mem_rvalid, drive rf_we and load_fault to 0, and keep mem_req and mem_addr stable.
REQ-032 SHALL allow a new instruction to be accepted in the same cycle that rf_we is asserted for the previous one (back-to-back non-loads at 1 per cycle).

Reset
REQ-033 SHALL, when rst_n=0 at a clock edge, regardless of clk_enable, set state to IDLE, the timeout count to 0, and mem_req, mem_addr, rf_we, rf_waddr, rf_wdata and load_fault to 0.
REQ-034 SHALL let reset during LOAD_WAIT abandon the load with no write and no fault, and SHALL have wb_ready=1 in the first cycle after reset.

Verification
REQ-035 SHALL cover: non-load with pre_wb=0x1234_5678 and rd=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678.
REQ-036 SHALL cover: LB at pre_wb=0x0000_0103 with mem_rdata=0x80FF_0000 after 3 wait cycles -> mem_addr=0x40, mem_req held 3 cycles, rf_wdata=0xFFFF_FF80.
REQ-037 SHALL cover: LHU at offset 2 with mem_rdata=0xBEEF_1234 -> rf_wdata=0x0000_BEEF; LW at pre_wb=0x...2 -> load_fault pulse, no mem_req, no rf_we.
REQ-038 SHALL cover: load with mem_rvalid never asserted -> load_fault exactly TIMEOUT_CYCLES cycles into LOAD_WAIT; a later mem_rvalid causes no write.
REQ-039 SHALL cover: clk_enable=0 for 4 cycles mid-LOAD_WAIT with mem_rvalid pulsed -> response ignored, mem_req stays 1 and the count is frozen; the load completes on a later mem_rvalid.
REQ-040 SHALL cover: rst_n=0 during LOAD_WAIT -> next cycle all outputs 0 and wb_ready=1; a non-load with rd=0 -> no rf_we.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results to the register file and performs loads
// through a single-outstanding read port with alignment checks and a response timeout.
module writeback_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] pre_wb,
    input  logic [4:0]  rd,
    input  logic        load_en,
    input  logic [2:0]  load_funct3,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        load_fault
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d;

    logic [4:0]  ld_rd, ld_rd_d;
    logic [2:0]  ld_funct3, ld_funct3_d;
    logic [1:0]  ld_off, ld_off_d;

    logic        mem_req_d;
    logic [29:0] mem_addr_d;
    logic        rf_we_d;
    logic [4:0]  rf_waddr_d;
    logic [31:0] rf_wdata_d;
    logic        load_fault_d;

    logic        accept, load_legal, rsp, tmo;
    logic [31:0] shifted, load_data;
    logic [15:0] half;

    assign wb_ready = (state == IDLE);
    assign accept   = clk_enable & wb_valid & (state == IDLE);
    assign rsp      = clk_enable & (state == LOAD_WAIT) & mem_rvalid;
    assign tmo      = clk_enable & (state == LOAD_WAIT) & ~mem_rvalid
                      & (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        load_legal = 1'b0;
        case (load_funct3)
            3'b000, 3'b100: load_legal = 1'b1;
            3'b001, 3'b101: load_legal = ~pre_wb[0];
            3'b010:         load_legal = (pre_wb[1:0] == 2'b00);
            default:        load_legal = 1'b0;
        endcase
    end

    // Lane selection uses the offset captured at accept, not the live pre_wb.
    assign shifted = mem_rdata >> {ld_off, 3'b000};
    assign half    = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (ld_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'h000000, shifted[7:0]};
            3'b001:  load_data = {{16{half[15]}}, half};
            3'b101:  load_data = {16'h0000, half};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_rd      <= '0;
            ld_funct3  <= '0;
            ld_off     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            load_fault <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            ld_rd      <= ld_rd_d;
            ld_funct3  <= ld_funct3_d;
            ld_off     <= ld_off_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            rf_we      <= rf_we_d;
            rf_waddr   <= rf_waddr_d;
            rf_wdata   <= rf_wdata_d;
            load_fault <= load_fault_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (accept && load_en && load_legal) begin
                        state_d = LOAD_WAIT;
                        cnt_d   = '0;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid || tmo) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pulses default low every edge; everything else holds unless updated.
    always_comb begin
        ld_rd_d      = ld_rd;
        ld_funct3_d  = ld_funct3;
        ld_off_d     = ld_off;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr;
        rf_wdata_d   = rf_wdata;
        load_fault_d = 1'b0;
        if (accept) begin
            if (!load_en) begin
                rf_we_d    = (rd != 5'd0);
                rf_waddr_d = rd;
                rf_wdata_d = pre_wb;
            end else if (load_legal) begin
                mem_req_d   = 1'b1;
                mem_addr_d  = pre_wb[31:2];
                ld_rd_d     = rd;
                ld_funct3_d = load_funct3;
                ld_off_d    = pre_wb[1:0];
            end else begin
                load_fault_d = 1'b1;
            end
        end
        if (rsp) begin
            mem_req_d  = 1'b0;
            rf_we_d    = (ld_rd != 5'd0);
            rf_waddr_d = ld_rd;
            rf_wdata_d = load_data;
        end
        if (tmo) begin
            mem_req_d    = 1'b0;
            load_fault_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against an arithmetic model
// of load extraction, alignment faults and the load timeout.
module tb_writeback_stage;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] pre_wb;
    logic [4:0]  rd;
    logic        load_en;
    logic [2:0]  load_funct3;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_fault;

    int total = 0;
    int bad   = 0;

    writeback_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .pre_wb(pre_wb), .rd(rd),
        .load_en(load_en), .load_funct3(load_funct3),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .load_fault(load_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value a load of the given type and byte offset writes back.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned o = int'(off);
        int unsigned b = (w >> (8 * o)) % 256;
        int unsigned h = (w >> (16 * (o / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_fault(input logic [2:0] f3, input logic [1:0] off);
        int unsigned o = int'(off);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (o % 2) != 0;
            3'd2:       return o != 0;
            default:    return 1'b1;
        endcase
    endfunction

    task automatic issue(input logic [31:0] a, input logic [4:0] r, input logic l,
                         input logic [2:0] f3);
        wb_valid = 1'b1; pre_wb = a; rd = r; load_en = l; load_funct3 = f3;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] a, input logic [4:0] r, input logic [2:0] f3,
                            input logic [31:0] w, input int unsigned waits, input bit stalls);
        issue(a, r, 1'b1, f3);
        chk1("ld_req", mem_req, 1'b1);
        chk32("ld_addr", {2'b00, mem_addr}, {2'b00, a[31:2]});
        chk1("ld_ready", wb_ready, 1'b0);
        mem_rdata = w;
        for (int unsigned i = 1; i < waits; i++) begin
            if (stalls && $urandom_range(0, 1) == 1) begin
                clk_enable = 1'b0; mem_rvalid = 1'b1;
                tick();
                chk1("stall_req", mem_req, 1'b1);
                chk1("stall_we", rf_we, 1'b0);
                clk_enable = 1'b1; mem_rvalid = 1'b0;
            end
            tick();
            chk1("wait_req", mem_req, 1'b1);
        end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk1("rsp_req", mem_req, 1'b0);
        chk1("rsp_we", rf_we, r != 5'd0);
        chk1("rsp_ready", wb_ready, 1'b1);
        if (r != 5'd0) begin
            chk32("rsp_waddr", {27'd0, rf_waddr}, {27'd0, r});
            chk32("rsp_wdata", rf_wdata, ref_load(f3, a[1:0], w));
        end
    endtask

    initial begin
        int unsigned n;
        logic [31:0] a, w;
        logic [4:0]  r;
        logic [2:0]  f3;
        logic        l;

        rst_n = 1'b0; clk_enable = 1'b1; wb_valid = 1'b0; pre_wb = '0; rd = '0;
        load_en = 1'b0; load_funct3 = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        tick(); tick();
        chk1("rst_we", rf_we, 1'b0);
        chk1("rst_fault", load_fault, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk32("rst_addr", {2'b00, mem_addr}, 32'd0);
        chk32("rst_wdata", rf_wdata, 32'd0);
        chk1("rst_ready", wb_ready, 1'b1);
        rst_n = 1'b1;

        // Non-load retirement and back-to-back acceptance
        issue(32'h1234_5678, 5'd5, 1'b0, 3'd0);
        chk1("nl_we", rf_we, 1'b1);
        chk32("nl_waddr", {27'd0, rf_waddr}, 32'd5);
        chk32("nl_wdata", rf_wdata, 32'h1234_5678);
        tick();
        chk1("nl_we_clr", rf_we, 1'b0);
        wb_valid = 1'b1; pre_wb = 32'hAAAA_0001; rd = 5'd9; load_en = 1'b0;
        tick();
        chk32("b2b_a", rf_wdata, 32'hAAAA_0001);
        pre_wb = 32'h5555_0002; rd = 5'd10;
        tick();
        wb_valid = 1'b0;
        chk1("b2b_we", rf_we, 1'b1);
        chk32("b2b_b", rf_wdata, 32'h5555_0002);
        chk32("b2b_waddr", {27'd0, rf_waddr}, 32'd10);

        // LB at 0x103, three cycles of mem_req
        run_load(32'h0000_0103, 5'd7, 3'd0, 32'h80FF_0000, 3, 1'b0);
        chk32("lb_val", rf_wdata, 32'hFFFF_FF80);
        run_load(32'h0000_2002, 5'd3, 3'd5, 32'hBEEF_1234, 1, 1'b0);
        chk32("lhu_val", rf_wdata, 32'h0000_BEEF);

        // Misaligned and illegal loads fault without a request
        issue(32'h0000_0012, 5'd4, 1'b1, 3'd2);
        chk1("lw_mis_fault", load_fault, 1'b1);
        chk1("lw_mis_req", mem_req, 1'b0);
        chk1("lw_mis_we", rf_we, 1'b0);
        chk1("lw_mis_ready", wb_ready, 1'b1);
        tick();
        chk1("fault_clr", load_fault, 1'b0);
        chk1("fault_noreq", mem_req, 1'b0);
        for (int k = 0; k < 5; k++) begin
            f3 = (k == 0) ? 3'd1 : (k == 1) ? 3'd5 : (k == 2) ? 3'd3 : (k == 3) ? 3'd6 : 3'd7;
            issue(32'h0000_0043, 5'd8, 1'b1, f3);
            chk1("bad_fault", load_fault, 1'b1);
            chk1("bad_req", mem_req, 1'b0);
        end

        // Timeout after exactly T cycles of waiting; a late response is ignored
        issue(32'h0000_0400, 5'd6, 1'b1, 3'd2);
        n = 0;
        while (mem_req === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk32("tmo_cycles", n, T);
        chk1("tmo_fault", load_fault, 1'b1);
        chk1("tmo_we", rf_we, 1'b0);
        chk1("tmo_ready", wb_ready, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        chk1("late_we", rf_we, 1'b0);
        chk1("late_fault", load_fault, 1'b0);
        chk1("late_req", mem_req, 1'b0);

        // Stall mid-wait: responses ignored, count frozen
        issue(32'h0000_0800, 5'd11, 1'b1, 3'd4);
        mem_rdata = 32'h00C3_0000;
        tick();
        clk_enable = 1'b0; mem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("stl_req", mem_req, 1'b1);
            chk1("stl_we", rf_we, 1'b0);
            chk1("stl_fault", load_fault, 1'b0);
            chk32("stl_addr", {2'b00, mem_addr}, 32'h0000_0200);
        end
        clk_enable = 1'b1; mem_rvalid = 1'b0;
        for (int k = 0; k < int'(T) - 2; k++) begin
            tick();
            chk1("stl_hold", mem_req, 1'b1);
        end
        chk1("stl_nofault", load_fault, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00C3;
        tick();
        mem_rvalid = 1'b0;
        chk1("stl_done_we", rf_we, 1'b1);
        chk32("stl_done_val", rf_wdata, 32'h0000_00C3);

        // Reset abandons an outstanding load
        issue(32'h0000_0100, 5'd12, 1'b1, 3'd2);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("rl_req", mem_req, 1'b0);
        chk1("rl_we", rf_we, 1'b0);
        chk1("rl_fault", load_fault, 1'b0);
        chk32("rl_addr", {2'b00, mem_addr}, 32'd0);
        chk1("rl_ready", wb_ready, 1'b1);
        issue(32'hDEAD_BEEF, 5'd0, 1'b0, 3'd0);
        chk1("x0_we", rf_we, 1'b0);
        chk1("x0_ready", wb_ready, 1'b1);

        // Randomized mix
        for (int k = 0; k < 60; k++) begin
            a  = $urandom;
            w  = $urandom;
            r  = 5'($urandom_range(0, 31));
            f3 = 3'($urandom_range(0, 7));
            l  = ($urandom_range(0, 3) != 0);
            if (!l) begin
                issue(a, r, 1'b0, f3);
                chk1("rnd_nl_we", rf_we, r != 5'd0);
                if (r != 5'd0) chk32("rnd_nl_wdata", rf_wdata, a);
            end else if (ref_fault(f3, a[1:0])) begin
                issue(a, r, 1'b1, f3);
                chk1("rnd_fault", load_fault, 1'b1);
                chk1("rnd_fault_req", mem_req, 1'b0);
                chk1("rnd_fault_we", rf_we, 1'b0);
            end else begin
                run_load(a, r, f3, w, $urandom_range(1, 3), 1'b1);
            end
        end
        tick();
        chk1("end_we", rf_we, 1'b0);
        chk1("end_fault", load_fault, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
